// File: rtl/ivc_state_ctrl_if.sv
// Handshake bundle between one input-VC controller, its flit buffer, the VC allocator and the switch allocator.
// The master side is the controller itself; the slave side is the surrounding router logic.
`ifndef N
`define N 5
`endif
`ifndef V
`define V 4
`endif

interface ivc_state_ctrl_if #(
    parameter int COORD_W = 4
);
    logic                  bufNonEmpty;
    logic [1:0]            frontType;
    logic [COORD_W-1:0]    frontDstX;
    logic [COORD_W-1:0]    frontDstY;
    logic [`N-1:0]         reqPort;
    logic [`V-1:0]         reqVC;
    logic                  vaGrant;
    logic [`V-1:0]         vaSelVC;
    logic [`V-1:0]         allocVC;
    logic [`N*`V-1:0]      creditAvail;
    logic                  swReq;
    logic                  swGrant;
    logic                  vcRelease;
    logic                  protoErr;

    modport master (
        input  bufNonEmpty, frontType, frontDstX, frontDstY,
        input  vaGrant, vaSelVC, creditAvail, swGrant,
        output reqPort, reqVC, allocVC, swReq, vcRelease, protoErr
    );

    modport slave (
        output bufNonEmpty, frontType, frontDstX, frontDstY,
        output vaGrant, vaSelVC, creditAvail, swGrant,
        input  reqPort, reqVC, allocVC, swReq, vcRelease, protoErr
    );
endinterface

// File: rtl/ivc_state_ctrl.sv
// Per-input-VC packet controller: XY route, VC allocation request, switch request gating and
// output-VC release on tail departure. One packet in flight at a time.
`ifndef N
`define N 5
`endif
`ifndef V
`define V 4
`endif

module ivc_state_ctrl #(
    parameter int                  COORD_W = 4,
    parameter logic [COORD_W-1:0]  LOCAL_X = '0,
    parameter logic [COORD_W-1:0]  LOCAL_Y = '0,
    parameter logic [`V-1:0]       VC_MASK = {`V{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    ivc_state_ctrl_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ROUTING  = 2'b01,
        VC_ALLOC = 2'b10,
        ACTIVE   = 2'b11
    } state_e;

    localparam logic [`V-1:0] VC_ONE = {{(`V-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [`N-1:0]   reqPort_q, reqPort_d;
    logic [`V-1:0]   allocVC_q, allocVC_d;
    logic            vcRelease_q, vcRelease_d;
    logic            protoErr_q, protoErr_d;

    logic [`N-1:0]   routePort;
    logic            selCredit;
    logic            swReqInt;
    logic            isHead;
    logic            isTail;
    logic            vaSelOneHot;

    // Type encoding: bit0 marks a head (01, 11), bit1 marks a tail (10, 11).
    assign isHead      = bus.frontType[0];
    assign isTail      = bus.frontType[1];
    assign vaSelOneHot = (bus.vaSelVC != '0) && ((bus.vaSelVC & (bus.vaSelVC - VC_ONE)) == '0);

    always_comb begin
        routePort = '0;
        if (bus.frontDstX > LOCAL_X) begin
            routePort[1] = 1'b1;
        end else if (bus.frontDstX < LOCAL_X) begin
            routePort[2] = 1'b1;
        end else if (bus.frontDstY > LOCAL_Y) begin
            routePort[3] = 1'b1;
        end else if (bus.frontDstY < LOCAL_Y) begin
            routePort[4] = 1'b1;
        end else begin
            routePort[0] = 1'b1;
        end
    end

    // Both selectors are one-hot, so an AND-OR mux picks the single credit bit without encoding.
    always_comb begin
        selCredit = 1'b0;
        for (int p = 0; p < `N; p++) begin
            for (int v = 0; v < `V; v++) begin
                selCredit = selCredit | (reqPort_q[p] & allocVC_q[v] & bus.creditAvail[p*`V + v]);
            end
        end
    end

    assign swReqInt = (state_q == ACTIVE) & bus.bufNonEmpty & selCredit;

    always_comb begin
        state_d     = state_q;
        reqPort_d   = reqPort_q;
        allocVC_d   = allocVC_q;
        vcRelease_d = 1'b0;
        protoErr_d  = protoErr_q;

        if (bus.swGrant && !swReqInt) begin
            protoErr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.bufNonEmpty) begin
                    if (isHead) begin
                        state_d = ROUTING;
                    end else begin
                        protoErr_d = 1'b1;
                    end
                end
            end
            ROUTING: begin
                reqPort_d = routePort;
                state_d   = VC_ALLOC;
            end
            VC_ALLOC: begin
                if (bus.vaGrant) begin
                    allocVC_d = bus.vaSelVC;
                    state_d   = ACTIVE;
                    if (!vaSelOneHot) begin
                        protoErr_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (bus.swGrant && swReqInt && isTail) begin
                    vcRelease_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            reqPort_q   <= '0;
            allocVC_q   <= '0;
            vcRelease_q <= 1'b0;
            protoErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqPort_q   <= reqPort_d;
            allocVC_q   <= allocVC_d;
            vcRelease_q <= vcRelease_d;
            protoErr_q  <= protoErr_d;
        end
    end

    assign bus.reqPort   = reqPort_q;
    assign bus.reqVC     = (state_q == VC_ALLOC) ? VC_MASK : '0;
    assign bus.allocVC   = allocVC_q;
    assign bus.swReq     = swReqInt;
    assign bus.vcRelease = vcRelease_q;
    assign bus.protoErr  = protoErr_q;

endmodule
